// File: rtl/branch_resolve_execute.sv
// ---------------------------------------------------------------------------
// branch_resolve_execute
//
// Execute-stage half of the PC-redirect path. Holds the ID/EX register for
// the control-flow fields of an instruction and resolves branches and jumps.
// Prediction is static not-taken, so every taken branch or jump redirects
// fetch. The instruction fetched behind the branch is squashed, and the link
// value is produced for JAL/JALR writeback. PCs are word addresses:
// sequential increment is 1, and immediates are already in word units.
//
// Parameters
//   XLEN   datapath and PC width
//   CNT_W  width of each statistics counter (used only with the stats build)
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   validD                   D stage holds a real instruction
//   branchD, jumpD, jalrD    conditional branch / JAL / JALR
//   funct3D                  branch condition code
//   pcD, pcincr4D            PC of the D instruction and pcD+1
//   immD                     sign-extended immediate, in word units
//   rs1D, rs2D               forwarded register operands
//   stallE                   hold the E register (downstream hazard)
//   pcsrcE, pctargetE        redirect select and redirect target for fetch
//   flushD                   discard the wrong-path instruction in D
//   linkE                    pcincr4 of the E instruction, for rd of JAL/JALR
//   validE                   E register holds a real instruction
//   stat_branches, stat_taken  resolved-branch and redirect counters
//
// Build option
//   BRANCH_STATS_EN  when defined, builds the two statistics counters.
//                    When undefined, the stat outputs are tied to zero.
// ---------------------------------------------------------------------------
module branch_resolve_execute #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             validD,
  input  logic             branchD,
  input  logic             jumpD,
  input  logic             jalrD,
  input  logic [2:0]       funct3D,
  input  logic [XLEN-1:0]  pcD,
  input  logic [XLEN-1:0]  pcincr4D,
  input  logic [XLEN-1:0]  immD,
  input  logic [XLEN-1:0]  rs1D,
  input  logic [XLEN-1:0]  rs2D,
  input  logic             stallE,
  output logic             pcsrcE,
  output logic [XLEN-1:0]  pctargetE,
  output logic             flushD,
  output logic [XLEN-1:0]  linkE,
  output logic             validE,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_taken
);

  typedef enum logic {IDLE, REDIRECTED} state_t;

  state_t state_q, state_d;

  logic            validE_q, branchE_q, jumpE_q, jalrE_q;
  logic [2:0]      funct3E_q;
  logic [XLEN-1:0] pcE_q, pcIncrE_q, immE_q, rs1E_q, rs2E_q;

  logic            condMet;
  logic            takeE;
  logic            loadBubble;

  // Branch condition from funct3. Codes 010 and 011 have no branch meaning
  // and never take.
  always_comb begin
    condMet = 1'b0;
    case (funct3E_q)
      3'b000:  condMet = (rs1E_q == rs2E_q);
      3'b001:  condMet = (rs1E_q != rs2E_q);
      3'b100:  condMet = ($signed(rs1E_q) <  $signed(rs2E_q));
      3'b101:  condMet = ($signed(rs1E_q) >= $signed(rs2E_q));
      3'b110:  condMet = (rs1E_q <  rs2E_q);
      3'b111:  condMet = (rs1E_q >= rs2E_q);
      default: condMet = 1'b0;
    endcase
  end

  // A bubble in E never redirects. JALR has priority over JAL and branch
  // for the target, because it is the only one that bases off rs1.
  assign takeE     = validE_q & (jumpE_q | jalrE_q | (branchE_q & condMet));
  assign pctargetE = jalrE_q ? (rs1E_q + immE_q) : (pcE_q + immE_q);
  assign linkE     = pcIncrE_q;
  assign validE    = validE_q;

  // The instruction behind a redirect must not enter E. This holds both on
  // the redirect cycle itself and when the redirect was issued during a
  // stall, in which case the squash happens on the first unstalled edge.
  assign loadBubble = pcsrcE | (state_q == REDIRECTED);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a redirect that is stalled in E is remembered, so the held
  // instruction does not redirect a second time. Leave on the first
  // unstalled edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (takeE && stallE) state_d = REDIRECTED;
      REDIRECTED: if (!stallE)         state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // FSM outputs: only the first cycle of a taken instruction in E
  // redirects fetch and flushes D.
  always_comb begin
    pcsrcE = 1'b0;
    flushD = 1'b0;
    if (state_q == IDLE) begin
      pcsrcE = takeE;
      flushD = takeE;
    end
  end

  // ID/EX register. Reset clears everything. A stall holds all fields.
  // A squash loads a bubble with its control bits cleared. Otherwise the
  // D instruction moves in.
  always_ff @(posedge clk) begin
    if (rst) begin
      validE_q  <= 1'b0;
      branchE_q <= 1'b0;
      jumpE_q   <= 1'b0;
      jalrE_q   <= 1'b0;
      funct3E_q <= '0;
      pcE_q     <= '0;
      pcIncrE_q <= '0;
      immE_q    <= '0;
      rs1E_q    <= '0;
      rs2E_q    <= '0;
    end else if (!stallE) begin
      pcE_q     <= pcD;
      pcIncrE_q <= pcincr4D;
      immE_q    <= immD;
      rs1E_q    <= rs1D;
      rs2E_q    <= rs2D;
      if (loadBubble) begin
        validE_q  <= 1'b0;
        branchE_q <= 1'b0;
        jumpE_q   <= 1'b0;
        jalrE_q   <= 1'b0;
        funct3E_q <= '0;
      end else begin
        validE_q  <= validD;
        branchE_q <= branchD;
        jumpE_q   <= jumpD;
        jalrE_q   <= jalrD;
        funct3E_q <= funct3D;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] statBranches_q, statTaken_q;

  // A branch is counted once, on the edge where it leaves E. Redirects are
  // counted on the single cycle where pcsrcE pulses. Both counters wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      statBranches_q <= '0;
      statTaken_q    <= '0;
    end else begin
      if (!stallE && validE_q && branchE_q) statBranches_q <= statBranches_q + CNT_W'(1);
      if (pcsrcE)                           statTaken_q    <= statTaken_q + CNT_W'(1);
    end
  end

  assign stat_branches = statBranches_q;
  assign stat_taken    = statTaken_q;
`else
  assign stat_branches = '0;
  assign stat_taken    = '0;
`endif

endmodule
